// File: rtl/mem_stage.sv
// Memory stage: latches EX results, waits for the SRAM response to a load or store, then aligns and extends the load data for WB.
// It holds one instruction and adds no cycle of latency once ready; a response that arrives while WB stalls is buffered. Optional macro: MEM_LOAD_FWD_EN.
module mem_stage (
   input  logic        clk,
   input  logic        resetn,
   output logic        mem_allowin,
   input  logic        ex_to_mem_valid,
   input  logic [74:0] ex_to_mem_bus,
   input  logic        wb_allowin,
   output logic        mem_to_wb_valid,
   output logic [69:0] mem_to_wb_bus,
   output logic [39:0] mem_to_id_bus,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata
);

   localparam int EX_TO_MEM_WD = 75;
   localparam int MEM_TO_WB_WD = 70;
   localparam int MEM_TO_ID_WD = 40;

   typedef struct packed {
      logic        req;
      logic        res_from_mem;
      logic [2:0]  ld_type;
      logic        regw;
      logic [4:0]  regw_addr;
      logic [31:0] alu_res;
      logic [31:0] pc;
   } ex_bus_t;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   ex_bus_t ex_in;
   ex_bus_t ins_q, ins_d;
   logic    mem_valid_q, mem_valid_d;
   logic    buf_valid_q, buf_valid_d;
   logic [31:0] buf_q, buf_d;
   state_t  state_q, state_d;

   logic        dok;
   logic        ready_go;
   logic        fwd_ready;
   logic [31:0] raw;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] regw_data;

   assign ex_in = ex_to_mem_bus;

   // A response only counts for a valid, requesting instruction that has not already captured one.
   assign dok             = data_sram_data_ok & mem_valid_q & ins_q.req & ~buf_valid_q;
   assign ready_go        = ~ins_q.req | dok | buf_valid_q;
   assign mem_allowin     = ~mem_valid_q | (ready_go & wb_allowin);
   assign mem_to_wb_valid = mem_valid_q & ready_go;

   always_comb begin
      raw     = buf_valid_q ? buf_q : data_sram_rdata;
      ld_byte = 8'(raw >> {ins_q.alu_res[1:0], 3'b000});
      ld_half = ins_q.alu_res[1] ? raw[31:16] : raw[15:0];
      case (ins_q.ld_type)
         3'b001:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b010:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b011:  ld_data = {24'd0, ld_byte};
         3'b100:  ld_data = {16'd0, ld_half};
         default: ld_data = raw;
      endcase
      regw_data = ins_q.res_from_mem ? ld_data : ins_q.alu_res;
   end

`ifdef MEM_LOAD_FWD_EN
   assign fwd_ready = ~ins_q.res_from_mem | dok | buf_valid_q;
`else
   assign fwd_ready = ~ins_q.res_from_mem;
`endif

   assign mem_to_wb_bus = {ins_q.regw, ins_q.regw_addr, regw_data, ins_q.pc};
   assign mem_to_id_bus = {mem_valid_q, ins_q.regw & mem_valid_q, fwd_ready,
                           ins_q.regw_addr, regw_data};

   always_comb begin
      mem_valid_d = mem_valid_q;
      ins_d       = ins_q;
      buf_valid_d = buf_valid_q;
      buf_d       = buf_q;
      state_d     = state_q;
      if (mem_allowin) begin
         // The leaving instruction's response (if any) went straight to WB; start clean.
         mem_valid_d = ex_to_mem_valid;
         buf_valid_d = 1'b0;
         if (ex_to_mem_valid) begin
            ins_d = ex_in;
         end
         state_d = (ex_to_mem_valid & ex_in.req) ? S_WAIT : S_IDLE;
      end else if (dok) begin
         buf_valid_d = 1'b1;
         buf_d       = data_sram_rdata;
         if (state_q == S_WAIT) begin
            state_d = S_HOLD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_valid_q <= 1'b0;
         ins_q       <= '0;
         buf_valid_q <= 1'b0;
         buf_q       <= '0;
         state_q     <= S_IDLE;
      end else begin
         mem_valid_q <= mem_valid_d;
         ins_q       <= ins_d;
         buf_valid_q <= buf_valid_d;
         buf_q       <= buf_d;
         state_q     <= state_d;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a table of single-instruction cases, hand-written multi-cycle sequences, then random traffic against a transaction-level model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        allowin;
   logic        ex_valid;
   logic [74:0] ex_bus;
   logic        wb_allowin;
   logic        wb_valid;
   logic [69:0] wb_bus;
   logic [39:0] id_bus;
   logic        dok;
   logic [31:0] rdata;

   int total = 0;
   int bad   = 0;

`ifdef MEM_LOAD_FWD_EN
   localparam logic FWD_EN = 1'b1;
`else
   localparam logic FWD_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_stage dut (
      .clk              (clk),
      .resetn           (resetn),
      .mem_allowin      (allowin),
      .ex_to_mem_valid  (ex_valid),
      .ex_to_mem_bus    (ex_bus),
      .wb_allowin       (wb_allowin),
      .mem_to_wb_valid  (wb_valid),
      .mem_to_wb_bus    (wb_bus),
      .mem_to_id_bus    (id_bus),
      .data_sram_data_ok(dok),
      .data_sram_rdata  (rdata)
   );

   typedef struct {
      string       name;
      logic        req;
      logic        rfm;
      logic [2:0]  ld;
      logic        regw;
      logic [31:0] alu;
      logic [31:0] rdat;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[11];

   function automatic vec_t mkv(input string n, input logic rq, input logic rf, input logic [2:0] ld,
                                input logic rw, input logic [31:0] alu, input logic [31:0] rd,
                                input logic [31:0] ex);
      vec_t v;
      v.name = n; v.req = rq; v.rfm = rf; v.ld = ld; v.regw = rw;
      v.alu = alu; v.rdat = rd; v.exp = ex;
      return v;
   endfunction

   function automatic logic [74:0] mkbus(input logic rq, input logic rf, input logic [2:0] ld,
                                         input logic rw, input logic [4:0] addr,
                                         input logic [31:0] alu, input logic [31:0] pc);
      return {rq, rf, ld, rw, addr, alu, pc};
   endfunction

   // Load result straight from the ISA definition of each load type.
   function automatic logic [31:0] ext(input logic [2:0] ld, input logic [1:0] off, input logic [31:0] r);
      int unsigned b, h, w;
      w = r;
      b = (w >> (8 * off)) % 256;
      h = off[1] ? (w / 65536) : (w % 65536);
      case (ld)
         3'd1:    return (b >= 128) ? b - 256 : b;
         3'd2:    return (h >= 32768) ? h - 65536 : h;
         3'd3:    return b;
         3'd4:    return h;
         default: return r;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Transaction-level model state: the instruction held, and whether its response arrived.
   logic        m_valid;
   logic [74:0] m_ins;
   logic        m_got;
   logic [31:0] m_data;

   initial begin
      logic        e_dok, e_go, e_allow, e_fwd, rrq, rrf;
      logic [31:0] e_raw, e_data;

      tbl[0]  = mkv("alu",      1'b0, 1'b0, 3'd0, 1'b1, 32'h1234_5678, 32'h0,         32'h1234_5678);
      tbl[1]  = mkv("ldb_off3", 1'b1, 1'b1, 3'd1, 1'b1, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
      tbl[2]  = mkv("ldbu_off3",1'b1, 1'b1, 3'd3, 1'b1, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
      tbl[3]  = mkv("ldh_off2", 1'b1, 1'b1, 3'd2, 1'b1, 32'h0000_0202, 32'hBEEF_1234, 32'hFFFF_BEEF);
      tbl[4]  = mkv("ldhu_off2",1'b1, 1'b1, 3'd4, 1'b1, 32'h0000_0202, 32'hBEEF_1234, 32'h0000_BEEF);
      tbl[5]  = mkv("ldh_off0", 1'b1, 1'b1, 3'd2, 1'b1, 32'h0000_0300, 32'hBEEF_1234, 32'h0000_1234);
      tbl[6]  = mkv("ldw",      1'b1, 1'b1, 3'd0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      tbl[7]  = mkv("ldb_off1", 1'b1, 1'b1, 3'd1, 1'b1, 32'h0000_0501, 32'h0000_7F00, 32'h0000_007F);
      tbl[8]  = mkv("ld_other", 1'b1, 1'b1, 3'd5, 1'b1, 32'h0000_0602, 32'hCAFE_F00D, 32'hCAFE_F00D);
      tbl[9]  = mkv("store",    1'b1, 1'b0, 3'd0, 1'b0, 32'h0000_1000, 32'h5555_AAAA, 32'h0000_1000);
      tbl[10] = mkv("ldb_off2", 1'b1, 1'b1, 3'd1, 1'b1, 32'h0000_0702, 32'h0080_0000, 32'hFFFF_FF80);

      resetn = 1'b0; ex_valid = 1'b0; ex_bus = '0; wb_allowin = 1'b1; dok = 1'b0; rdata = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_id_hi", id_bus[39:38], 0);
      chk("rst_allowin", allowin, 1);
      @(negedge clk);
      resetn = 1'b1;

      // Table: enter one instruction, answer its request one cycle later.
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         ex_valid = 1'b1; dok = 1'b0; wb_allowin = 1'b1; rdata = 32'h0BAD_0BAD;
         ex_bus = mkbus(tbl[i].req, tbl[i].rfm, tbl[i].ld, tbl[i].regw, 5'(i + 1), tbl[i].alu,
                        32'h1c00_0000 + 32'(i * 4));
         #1 chk({"tbl_allowin_", tbl[i].name}, allowin, 1);
         @(negedge clk);
         ex_valid = 1'b0;
         if (tbl[i].req) begin
            #1 chk({"tbl_wait_", tbl[i].name}, wb_valid, 0);
            @(negedge clk);
            dok = 1'b1; rdata = tbl[i].rdat;
         end
         #1;
         chk({"tbl_valid_", tbl[i].name}, wb_valid, 1);
         chk({"tbl_bus_", tbl[i].name}, wb_bus,
             {tbl[i].regw, 5'(i + 1), tbl[i].exp, 32'h1c00_0000 + 32'(i * 4)});
         @(negedge clk);
         dok = 1'b0;
         #1 chk({"tbl_empty_", tbl[i].name}, wb_valid, 0);
      end

      // ld.b with the response two idle cycles after entry.
      @(negedge clk);
      ex_valid = 1'b1; ex_bus = mkbus(1'b1, 1'b1, 3'd1, 1'b1, 5'd3, 32'h0000_0013, 32'h3000);
      @(negedge clk);
      ex_valid = 1'b0;
      #1 chk("ldb_wait1", wb_valid, 0);
      @(negedge clk);
      #1 chk("ldb_wait2", wb_valid, 0);
      @(negedge clk);
      dok = 1'b1; rdata = 32'h80FF_0000;
      #1 chk("ldb_valid", wb_valid, 1);
      chk("ldb_data", wb_bus[63:32], 32'hFFFF_FF80);
      @(negedge clk);
      dok = 1'b0;

      // ld.hu answered while WB stalls; buffered value must survive a stray response.
      @(negedge clk);
      ex_valid = 1'b1; wb_allowin = 1'b0; ex_bus = mkbus(1'b1, 1'b1, 3'd4, 1'b1, 5'd9, 32'h0000_0022, 32'h4000);
      @(negedge clk);
      ex_valid = 1'b0; dok = 1'b1; rdata = 32'hBEEF_1234;
      #1 chk("hold_first_valid", wb_valid, 1);
      chk("hold_first_allowin", allowin, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         dok = (k == 1); rdata = 32'h1111_2222;
         #1 chk("hold_valid", wb_valid, 1);
         chk("hold_data", wb_bus[63:32], 32'h0000_BEEF);
         chk("hold_allowin", allowin, 0);
      end
      @(negedge clk);
      dok = 1'b0; wb_allowin = 1'b1;
      #1 chk("hold_release_data", wb_bus[63:32], 32'h0000_BEEF);
      chk("hold_release_allowin", allowin, 1);
      @(negedge clk);
      #1 chk("hold_after", wb_valid, 0);

      // Back-to-back loads with a response every cycle.
      @(negedge clk);
      ex_valid = 1'b1; wb_allowin = 1'b1; dok = 1'b0;
      ex_bus = mkbus(1'b1, 1'b1, 3'd0, 1'b1, 5'd1, 32'h100, 32'h2000);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         ex_valid = (k < 5);
         ex_bus = mkbus(1'b1, 1'b1, 3'd0, 1'b1, 5'(k + 1), 32'h100 + 32'(k * 4), 32'h2000 + 32'(k * 4));
         dok = 1'b1; rdata = 32'hA000_0000 + 32'(k - 1);
         #1 chk("b2b_allowin", allowin, 1);
         chk("b2b_valid", wb_valid, 1);
         chk("b2b_bus", wb_bus, {1'b1, 5'(k), 32'hA000_0000 + 32'(k - 1), 32'h2000 + 32'((k - 1) * 4)});
      end
      @(negedge clk);
      dok = 1'b0;
      #1 chk("b2b_after", wb_valid, 0);

      // Reset while waiting, then a stray response for the discarded request.
      @(negedge clk);
      ex_valid = 1'b1; ex_bus = mkbus(1'b1, 1'b1, 3'd0, 1'b1, 5'd4, 32'h500, 32'h5000);
      @(negedge clk);
      ex_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1; dok = 1'b1; rdata = 32'h7777_7777;
      #1 chk("rstw_stray_valid", wb_valid, 0);
      chk("rstw_id_hi", id_bus[39:38], 0);
      @(negedge clk);
      dok = 1'b0; ex_valid = 1'b1; ex_bus = mkbus(1'b1, 1'b1, 3'd0, 1'b1, 5'd5, 32'h600, 32'h6000);
      @(negedge clk);
      ex_valid = 1'b0;
      #1 chk("rstw_no_stale_buf", wb_valid, 0);
      @(negedge clk);
      dok = 1'b1; rdata = 32'h0101_0202;
      #1 chk("rstw_new_data", wb_bus[63:32], 32'h0101_0202);

      // Forwarding readiness of a ld.w in MEM.
      @(negedge clk);
      dok = 1'b0; ex_valid = 1'b1; ex_bus = mkbus(1'b1, 1'b1, 3'd0, 1'b1, 5'd6, 32'h700, 32'h7000);
      @(negedge clk);
      ex_valid = 1'b0;
      #1 chk("fwd_wait", id_bus[39:37], 3'b110);
      @(negedge clk);
      dok = 1'b1; rdata = 32'h1357_9BDF;
      #1 chk("fwd_dok", id_bus[37], FWD_EN);
      chk("fwd_result", id_bus[31:0], 32'h1357_9BDF);
      @(negedge clk);
      dok = 1'b0;

      // Random traffic against the model.
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      m_valid = 1'b0; m_ins = '0; m_got = 1'b0; m_data = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rrq = 1'($urandom_range(0, 1));
         rrf = rrq & 1'($urandom_range(0, 1));
         ex_valid   = ($urandom_range(0, 9) < 6);
         ex_bus     = mkbus(rrq, rrf, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                            5'($urandom), $urandom, $urandom);
         wb_allowin = ($urandom_range(0, 9) < 7);
         dok        = ($urandom_range(0, 9) < 4);
         rdata      = $urandom;

         e_dok   = dok & m_valid & m_ins[74] & ~m_got;
         e_go    = m_valid & (~m_ins[74] | m_got | e_dok);
         e_allow = ~m_valid | (e_go & wb_allowin);
         e_raw   = m_got ? m_data : rdata;
         e_data  = m_ins[73] ? ext(m_ins[72:70], m_ins[33:32], e_raw) : m_ins[63:32];
         e_fwd   = FWD_EN ? (~m_ins[73] | e_dok | m_got) : ~m_ins[73];

         #1;
         chk("rnd_allowin", allowin, e_allow);
         chk("rnd_wb_valid", wb_valid, e_go);
         if (e_go) chk("rnd_wb_bus", wb_bus, {m_ins[69], m_ins[68:64], e_data, m_ins[31:0]});
         if (m_valid) chk("rnd_id_bus", id_bus, {1'b1, m_ins[69], e_fwd, m_ins[68:64], e_data});
         else         chk("rnd_id_hi", id_bus[39:38], 0);

         if (e_allow) begin
            m_valid = ex_valid;
            if (ex_valid) m_ins = ex_bus;
            m_got = 1'b0;
         end else if (e_dok) begin
            m_got  = 1'b1;
            m_data = rdata;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
